tpu_operand_loader: RTL and testbench
=====================================

// Module: tpu_operand_loader
// PURPOSE
//  Upstream feeder for the tinytpu systolic MAC array inside tt_um_revenantx86_tinytpu.
//  Accepts a byte stream from the top-level pins holding matrix A then matrix B (row-major, NxN each).
//  Replays them into the array with diagonal skew, after a one-cycle accumulator clear.
//  Row i of A is delayed i cycles; column j of B is delayed j cycles.
//  Signals completion so the readout stage can take the results.
// PARAMETERS
//  DATA_W  8  operand width in bits; opaque to this block, no arithmetic on operands
//  N       2  array dimension; the block holds 2*N*N operand registers
// PORTS
//  clk       in   1         single clock; all state is on its rising edge
//  rst       in   1         asynchronous, active-high reset
//  in_data   in   DATA_W    operand byte
//  in_valid  in   1         in_data valid
//  in_ready  out  1         loader accepts a byte; transfer = in_valid & in_ready
//  arr_clr   out  1         one-cycle pulse that clears the array accumulators
//  arr_en    out  1         array advances this cycle; a_out/b_out are valid
//  a_out     out  N*DATA_W  lane i = row-i input, bits [i*DATA_W +: DATA_W]
//  b_out     out  N*DATA_W  lane j = column-j input, same packing
//  done      out  1         one-cycle pulse after the last feed cycle
// BEHAVIOUR
//  Reset state:
//   - rst asserted at any time, including mid-load or mid-feed: state=LOAD_A and counters=0.
//   - Operand registers=0; arr_clr, arr_en, done, a_out and b_out all 0.
//   - in_ready=1 as soon as rst deasserts. A partial load or feed is discarded.
//  States: LOAD_A -> LOAD_B -> CLR -> FEED -> DONE -> LOAD_A.
//  LOAD_A / LOAD_B:
//   - in_ready=1.
//   - Each transfer writes element idx = byte_cnt (row = idx/N, col = idx%N), then byte_cnt increments.
//   - byte_cnt wraps to 0 at N*N and the state advances.
//   - in_valid=0 stalls with no limit. No timeout.
//  CLR:
//   - Lasts 1 cycle. arr_clr=1, arr_en=0, in_ready=0.
//  FEED:
//   - Lasts exactly 3N-2 cycles, t = 0..3N-3. arr_en=1, in_ready=0.
//   - a_out lane i = A[i][t-i] if 0 <= t-i < N, else 0.
//   - b_out lane j = B[t-j][j] if 0 <= t-j < N, else 0.
//   - Cycles with all-zero lanes are intentional; they drain the last products through the array.
//  DONE:
//   - Lasts 1 cycle. done=1, arr_en=0, a_out=b_out=0, in_ready=0.
//  Outputs arr_clr, arr_en, done, a_out and b_out are registered (no combinational path from in_*).
//  in_ready is decoded from the state register only.
//  Bytes presented while in_ready=0 are ignored and do not alter any state.
//  Operand registers keep their values after DONE. A new load overwrites them element by element.
//  Counters: byte_cnt is $clog2(N*N)+1 bits; t_cnt is $clog2(3N-2)+1 bits. Neither saturates; both reset on state exit.
// STRUCTURE
//  tpu_pkg holds:
//   - DATA_W and N defaults.
//   - state_t enum {LOAD_A, LOAD_B, CLR, FEED, DONE}.
//   - FEED_CYCLES = 3*N-2.
//  Sub-module tpu_skew_sel: combinational lane selector.
//   - Inputs: one NxN matrix, t_cnt, and the lane orientation (row/col).
//   - Output: the N skewed lanes.
//   - Instantiated twice, once for A and once for B.
//  FSM, counters and output registers live in tpu_operand_loader.
// TESTING (N=2, DATA_W=8, A=[1,2;3,4], B=[5,6;7,8])
//  1. Reset, then stream bytes 1..8 with in_valid held high.
//     -> in_ready=1 for 8 cycles, then arr_clr pulses once.
//     -> Feed (a_out, b_out) lanes: t0 a{1,0} b{5,0}; t1 a{2,3} b{7,6}; t2 a{0,4} b{0,8}; t3 a{0,0} b{0,0}.
//     -> done pulses on the next cycle.
//  2. Same stream with in_valid toggled 1/0 each cycle.
//     -> Same feed sequence. Load takes 16 cycles. No byte is dropped or duplicated.
//  3. Drive in_valid=1, in_data=0xFF throughout CLR/FEED/DONE.
//     -> Feed matches scenario 1. Next load begins only after DONE, with byte_cnt=0.
//  4. Assert rst after the 5th byte, then reload 8 bytes of 0x11.
//     -> All outputs go to 0 immediately (async).
//     -> The reload feeds 0x11 on all non-skewed lanes; no stale values appear.
//  5. Assert rst during FEED at t1.
//     -> arr_en=0 and a_out=b_out=0 immediately. No done pulse. in_ready=1 after release.
//  6. Run two back-to-back jobs; the second uses B=identity.
//     -> Second feed uses the new B. A lanes repeat. Exactly one done per job.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the tinytpu operand loader: default sizes, FSM states, feed length.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Ports: none.
package tpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N      = 2;

  // Skewed feed of an NxN product: last operand pair enters at t = 2N-2,
  // then N-1 further cycles drain it through the array.
  localparam int FEED_CYCLES = 3 * DEF_N - 2;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    CLR    = 3'd2,
    FEED   = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int feed_cycles(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/tpu_skew_sel.sv
// Combinational lane selector producing the diagonally skewed operand lanes for one feed cycle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the lanes are used.
// Ports: mat_i   - NxN matrix, element (r,c) at [(r*N+c)*DATA_W +: DATA_W]
//        t_i     - feed cycle index
//        col_mode_i - 0: lane l = mat[l][t-l] (A rows), 1: lane l = mat[t-l][l] (B columns)
//        lanes_o - N lanes, lane l at [l*DATA_W +: DATA_W]; out-of-window lanes are 0
module tpu_skew_sel
  import tpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N,
  parameter int TW     = 3
) (
  input  logic [N*N*DATA_W-1:0] mat_i,
  input  logic [TW-1:0]         t_i,
  input  logic                  col_mode_i,
  output logic [N*DATA_W-1:0]   lanes_o
);

  // Lane l carries element k of its row/column when t == l + k; loop indices
  // are constants so each lane reduces to an N-way mux keyed on t.
  always_comb begin
    lanes_o = '0;
    for (int l = 0; l < N; l++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t_i) == l + k) begin
          if (col_mode_i) begin
            lanes_o[l*DATA_W +: DATA_W] = mat_i[(k*N+l)*DATA_W +: DATA_W];
          end else begin
            lanes_o[l*DATA_W +: DATA_W] = mat_i[(l*N+k)*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/tpu_operand_loader.sv
// Loads matrices A then B from a byte stream and replays them skewed into the systolic MAC array.
// Latency: load N*N*2 accepted bytes, 1 clear cycle, 3N-2 feed cycles, 1 done cycle; outputs registered.
// Backpressure: in_ready is high only while loading; bytes offered in any other state are ignored.
// Ports: clk/rst (async active-high), in_data/in_valid/in_ready byte input,
//        arr_clr accumulator clear pulse, arr_en feed strobe, a_out/b_out skewed lanes,
//        done one-cycle completion pulse.
module tpu_operand_loader
  import tpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                arr_clr,
  output logic                arr_en,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N*DATA_W-1:0] b_out,
  output logic                done
);

  localparam int ELEMS    = N * N;
  localparam int FEED_LEN = feed_cycles(N);
  localparam int BW       = $clog2(ELEMS) + 1;
  localparam int TW       = $clog2(FEED_LEN) + 1;

  localparam logic [BW-1:0] LAST_BYTE = BW'(ELEMS - 1);
  localparam logic [TW-1:0] LAST_T    = TW'(FEED_LEN - 1);

  state_t                   state_q, state_d;
  logic [BW-1:0]            byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]            t_cnt_q, t_cnt_d;
  logic [ELEMS*DATA_W-1:0]  mat_a_q, mat_b_q;
  logic                     arr_clr_q, arr_en_q, done_q;
  logic [N*DATA_W-1:0]      a_out_q, b_out_q;
  logic [N*DATA_W-1:0]      lanes_a, lanes_b;
  logic                     xfer;

  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign xfer     = in_valid && in_ready;

  assign arr_clr = arr_clr_q;
  assign arr_en  = arr_en_q;
  assign done    = done_q;
  assign a_out   = a_out_q;
  assign b_out   = b_out_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    t_cnt_d    = t_cnt_q;
    unique case (state_q)
      LOAD_A, LOAD_B: begin
        if (xfer) begin
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = (state_q == LOAD_A) ? LOAD_B : CLR;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      CLR: begin
        state_d = FEED;
        t_cnt_d = '0;
      end
      FEED: begin
        if (t_cnt_q == LAST_T) begin
          state_d = DONE;
          t_cnt_d = '0;
        end else begin
          t_cnt_d = t_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Lanes are selected for the upcoming cycle (t_cnt_d) so the registered
  // outputs line up with the FSM state they describe.
  tpu_skew_sel #(.DATA_W(DATA_W), .N(N), .TW(TW)) u_skew_a (
    .mat_i      (mat_a_q),
    .t_i        (t_cnt_d),
    .col_mode_i (1'b0),
    .lanes_o    (lanes_a)
  );

  tpu_skew_sel #(.DATA_W(DATA_W), .N(N), .TW(TW)) u_skew_b (
    .mat_i      (mat_b_q),
    .t_i        (t_cnt_d),
    .col_mode_i (1'b1),
    .lanes_o    (lanes_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD_A;
      byte_cnt_q <= '0;
      t_cnt_q    <= '0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      arr_clr_q  <= 1'b0;
      arr_en_q   <= 1'b0;
      done_q     <= 1'b0;
      a_out_q    <= '0;
      b_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      t_cnt_q    <= t_cnt_d;
      for (int e = 0; e < ELEMS; e++) begin
        if (xfer && byte_cnt_q == BW'(e)) begin
          if (state_q == LOAD_A) mat_a_q[e*DATA_W +: DATA_W] <= in_data;
          if (state_q == LOAD_B) mat_b_q[e*DATA_W +: DATA_W] <= in_data;
        end
      end
      arr_clr_q <= (state_d == CLR);
      arr_en_q  <= (state_d == FEED);
      done_q    <= (state_d == DONE);
      a_out_q   <= (state_d == FEED) ? lanes_a : '0;
      b_out_q   <= (state_d == FEED) ? lanes_b : '0;
    end
  end

endmodule

// File: tb/tb_tpu_operand_loader.sv
// Self-checking bench for tpu_operand_loader (N=2, DATA_W=8) using an expected-feed queue.
// Latency: n/a.
// Backpressure: driver holds each byte until in_ready is seen.
module tb_tpu_operand_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        arr_clr;
  logic        arr_en;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic        done;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int done_cnt = 0;
  int clr_cnt = 0;
  int clr_cyc = 0;
  int last_en_cyc = 0;
  int done_cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [7:0]  tx_q[$];

  tpu_operand_loader #(.DATA_W(8), .N(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .arr_clr  (arr_clr),
    .arr_en   (arr_en),
    .a_out    (a_out),
    .b_out    (b_out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records observed feed words and pulse timing on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (arr_en === 1'b1) begin
        obs_q.push_back({a_out, b_out});
        last_en_cyc = cyc;
      end
      if (arr_clr === 1'b1) begin
        clr_cnt++;
        clr_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Queues the 8 bytes of a job and the 4 feed words it should produce.
  // Matrices are packed with element idx = row*2+col at [idx*8 +: 8].
  task automatic push_job(input logic [31:0] am, input logic [31:0] bm);
    logic [15:0] aw, bw;
    int k;
    for (int e = 0; e < 4; e++) tx_q.push_back(am[e*8 +: 8]);
    for (int e = 0; e < 4; e++) tx_q.push_back(bm[e*8 +: 8]);
    for (int t = 0; t < 4; t++) begin
      aw = '0;
      bw = '0;
      for (int l = 0; l < 2; l++) begin
        k = t - l;
        if (k >= 0 && k < 2) begin
          aw[l*8 +: 8] = am[(l*2+k)*8 +: 8];
          bw[l*8 +: 8] = bm[(k*2+l)*8 +: 8];
        end
      end
      exp_q.push_back({aw, bw});
    end
  endtask

  // Drives every byte of tx_q; with toggle, each byte is preceded by an idle cycle carrying junk data.
  task automatic send_all(input bit toggle, output bit ok, output int start_cyc);
    int n;
    ok = 1'b1;
    start_cyc = -1;
    while (tx_q.size() > 0) begin
      if (toggle) begin
        @(negedge clk);
        if (start_cyc < 0) start_cyc = cyc;
        in_valid = 1'b0;
        in_data  = 8'hEE;
      end
      @(negedge clk);
      if (start_cyc < 0) start_cyc = cyc;
      in_valid = 1'b1;
      in_data  = tx_q[0];
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (in_ready !== 1'b1) begin
        ok = 1'b0;
        tx_q.delete();
      end else begin
        void'(tx_q.pop_front());
      end
    end
  endtask

  // Waits for done; optionally keeps offering 0xFF meanwhile. Ends one cycle after done.
  task automatic wait_done(input int budget, input bit hold_ff, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
      end else begin
        in_valid = hold_ff;
        in_data  = hold_ff ? 8'hFF : 8'h00;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (arr_en !== 1'b0) begin failures++; $display("FAIL reset_arr_en got=%b want=0", arr_en); end
    checks++;
    if (arr_clr !== 1'b0) begin failures++; $display("FAIL reset_arr_clr got=%b want=0", arr_clr); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (a_out !== 16'h0 || b_out !== 16'h0) begin
      failures++; $display("FAIL reset_lanes got a=%h b=%h want 0000/0000", a_out, b_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    exp_q.delete();
    obs_q.delete();
    tx_q.delete();
  endtask

  task automatic test_stream_load();
    bit ok, got;
    int s0, c0, d0;
    logic [31:0] e, o;
    c0 = clr_cnt;
    d0 = done_cnt;
    exp_q.push_back({16'h0001, 16'h0005});
    exp_q.push_back({16'h0302, 16'h0607});
    exp_q.push_back({16'h0400, 16'h0800});
    exp_q.push_back({16'h0000, 16'h0000});
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    send_all(1'b0, ok, s0);
    checks++;
    if (!ok) begin failures++; $display("FAIL stream_load_timeout got=stall want=accept"); end
    wait_done(40, 1'b0, got);
    checks++;
    if (!got) begin failures++; $display("FAIL stream_done_timeout got=none want=done"); end
    checks++;
    if (clr_cyc - s0 != 8) begin failures++; $display("FAIL stream_load_cycles got=%0d want=8", clr_cyc - s0); end
    checks++;
    if (clr_cnt - c0 != 1) begin failures++; $display("FAIL stream_clr_pulses got=%0d want=1", clr_cnt - c0); end
    checks++;
    if (last_en_cyc - clr_cyc != 4) begin
      failures++; $display("FAIL stream_feed_len got=%0d want=4", last_en_cyc - clr_cyc);
    end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL stream_done_pulses got=%0d want=1", done_cnt - d0); end
    checks++;
    if (done_cyc != last_en_cyc + 1) begin
      failures++; $display("FAIL stream_done_timing got=%0d want=%0d", done_cyc, last_en_cyc + 1);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready_after_done got=%b want=1", in_ready); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL stream_feed missing word want=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL stream_feed got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL stream_extra_feed got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_toggle_valid();
    bit ok, got;
    int s0;
    logic [31:0] e, o;
    push_job(32'h04030201, 32'h08070605);
    send_all(1'b1, ok, s0);
    checks++;
    if (!ok) begin failures++; $display("FAIL toggle_load_timeout got=stall want=accept"); end
    wait_done(40, 1'b0, got);
    checks++;
    if (!got) begin failures++; $display("FAIL toggle_done_timeout got=none want=done"); end
    checks++;
    if (clr_cyc - s0 != 16) begin failures++; $display("FAIL toggle_load_cycles got=%0d want=16", clr_cyc - s0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL toggle_feed missing word want=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL toggle_feed got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL toggle_extra_feed got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_ignore_busy();
    bit ok, got;
    int s0;
    logic [31:0] e, o;
    push_job(32'h04030201, 32'h08070605);
    send_all(1'b0, ok, s0);
    wait_done(40, 1'b1, got);
    checks++;
    if (!ok || !got) begin failures++; $display("FAIL busy_job1 got ok=%b done=%b want 1/1", ok, got); end
    push_job(32'h0C0B0A09, 32'h100F0E0D);
    send_all(1'b0, ok, s0);
    wait_done(40, 1'b0, got);
    checks++;
    if (!ok || !got) begin failures++; $display("FAIL busy_job2 got ok=%b done=%b want 1/1", ok, got); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL busy_feed missing word want=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL busy_feed got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL busy_extra_feed got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    bit ok, got;
    int s0;
    logic [31:0] e, o;
    for (int i = 1; i <= 5; i++) tx_q.push_back(8'(i));
    send_all(1'b0, ok, s0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (arr_en !== 1'b0 || arr_clr !== 1'b0 || done !== 1'b0 || a_out !== 16'h0 || b_out !== 16'h0) begin
      failures++;
      $display("FAIL midload_rst_outputs got en=%b clr=%b done=%b a=%h b=%h want all 0",
               arr_en, arr_clr, done, a_out, b_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midload_ready got=%b want=1", in_ready); end
    push_job(32'h11111111, 32'h11111111);
    send_all(1'b0, ok, s0);
    wait_done(40, 1'b0, got);
    checks++;
    if (!ok || !got) begin failures++; $display("FAIL midload_reload got ok=%b done=%b want 1/1", ok, got); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL midload_feed missing word want=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL midload_feed got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL midload_extra_feed got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_feed();
    bit ok, got;
    int s0, d0;
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    send_all(1'b0, ok, s0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (arr_en === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL midfeed_no_feed got=none want=arr_en"); end
    @(posedge clk);
    #2;
    checks++;
    if (arr_en !== 1'b1 || in_ready !== 1'b0 || a_out !== 16'h0302 || b_out !== 16'h0607) begin
      failures++;
      $display("FAIL midfeed_t1 got en=%b rdy=%b a=%h b=%h want 1/0/0302/0607", arr_en, in_ready, a_out, b_out);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (arr_en !== 1'b0 || done !== 1'b0 || a_out !== 16'h0 || b_out !== 16'h0) begin
      failures++;
      $display("FAIL midfeed_rst_outputs got en=%b done=%b a=%h b=%h want all 0", arr_en, done, a_out, b_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midfeed_ready got=%b want=1", in_ready); end
    obs_q.delete();
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL midfeed_done got=%0d want=0", done_cnt - d0); end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL midfeed_stray_feed got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok, got;
    int s0, c0, d0;
    logic [31:0] e, o;
    c0 = clr_cnt;
    d0 = done_cnt;
    push_job(32'h04030201, 32'h08070605);
    push_job(32'h04030201, 32'h01000001);
    send_all(1'b0, ok, s0);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_load_timeout got=stall want=accept"); end
    wait_done(40, 1'b0, got);
    checks++;
    if (!got) begin failures++; $display("FAIL b2b_done_timeout got=none want=done"); end
    checks++;
    if (done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_done_pulses got=%0d want=2", done_cnt - d0); end
    checks++;
    if (clr_cnt - c0 != 2) begin failures++; $display("FAIL b2b_clr_pulses got=%0d want=2", clr_cnt - c0); end
    checks++;
    if (done_cyc != last_en_cyc + 1) begin
      failures++; $display("FAIL b2b_done_timing got=%0d want=%0d", done_cyc, last_en_cyc + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL b2b_feed missing word want=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL b2b_feed got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_extra_feed got=%0d want=0", obs_q.size()); end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #1;
    test_reset();
    test_stream_load();
    test_toggle_valid();
    test_ignore_busy();
    test_reset_mid_load();
    test_reset_mid_feed();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
